// File: rtl/mips_pkg.sv
// Shared types and constants for the 1-to-2 demultiplexer.
// Holds the FSM state encoding and the port-select codes.
package mips_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } demux_state_t;

    localparam logic SEL_PORT0 = 1'b0;
    localparam logic SEL_PORT1 = 1'b1;

endpackage

// File: rtl/demux_skid_reg.sv
// Load-enabled register with asynchronous active-high reset.
// Holds one {select, payload} entry of the demux.
module demux_skid_reg #(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/demux_i1_x2.sv
// Registered 1-to-2 demultiplexer with a two-entry skid and registered o_ready.
// Optional macro DEMUX_ZERO_IDLE_EN zeroes the payload on ports that are not valid.
module demux_i1_x2
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_control,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid0,
    input  logic                  i_ready0,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic                  o_valid1,
    input  logic                  i_ready1,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic [1:0]            o_dbg_state
);

    // Handshake (both sides): a transfer happens on a rising edge where
    // valid and ready are both high; a valid transfer holds until taken.

    demux_state_t r_state;
    demux_state_t w_next_state;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_out_valid;
    logic                  w_out_load;
    logic                  w_skid_load;
    logic                  w_out_from_skid;
    logic [DATA_WIDTH:0]   w_in_word;
    logic [DATA_WIDTH:0]   w_out_d;
    logic [DATA_WIDTH:0]   w_out_q;
    logic [DATA_WIDTH:0]   w_skid_q;
    logic                  w_out_sel;
    logic [DATA_WIDTH-1:0] w_out_data;

    assign w_in_word   = {((i_control == SEL_PORT1) ? SEL_PORT1 : SEL_PORT0), i_data};
    assign w_out_sel   = w_out_q[DATA_WIDTH];
    assign w_out_data  = w_out_q[DATA_WIDTH-1:0];
    assign w_out_valid = (r_state != EMPTY);
    assign w_ready     = (r_state != TWO) & ~i_rst;
    assign w_accept    = i_valid & w_ready;
    assign w_drain     = w_out_valid & (w_out_sel ? i_ready1 : i_ready0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_out_load      = 1'b0;
        w_skid_load     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_out_load   = 1'b1;
                    w_next_state = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_out_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load  = 1'b1;
                    w_next_state = TWO;
                end else if (w_drain) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                // Upstream is stalled here, so the skid entry is the only source.
                if (w_drain) begin
                    w_out_load      = 1'b1;
                    w_out_from_skid = 1'b1;
                    w_next_state    = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    assign w_out_d = w_out_from_skid ? w_skid_q : w_in_word;

    demux_skid_reg #(.WIDTH(DATA_WIDTH + 1)) u_out_reg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_out_load),
        .i_d    (w_out_d),
        .o_q    (w_out_q)
    );

    demux_skid_reg #(.WIDTH(DATA_WIDTH + 1)) u_skid_reg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_skid_load),
        .i_d    (w_in_word),
        .o_q    (w_skid_q)
    );

    assign o_ready     = w_ready;
    assign o_valid0    = w_out_valid & ~w_out_sel;
    assign o_valid1    = w_out_valid & w_out_sel;
    assign o_dbg_state = r_state;

`ifdef DEMUX_ZERO_IDLE_EN
    assign o_data0 = o_valid0 ? w_out_data : '0;
    assign o_data1 = o_valid1 ? w_out_data : '0;
`else
    assign o_data0 = w_out_data;
    assign o_data1 = w_out_data;
`endif

endmodule

// File: tb/tb_demux_i1_x2.sv
// Self-checking bench for demux_i1_x2: directed scenarios plus a random
// stream checked against an in-order scoreboard.
module tb_demux_i1_x2;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_control;
    logic [W-1:0] i_data;
    logic         o_valid0;
    logic         i_ready0;
    logic [W-1:0] o_data0;
    logic         o_valid1;
    logic         i_ready1;
    logic [W-1:0] o_data1;
    logic [1:0]   o_dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];
    logic [W:0] mon_exp;
    logic [W:0] mon_act;

    demux_i1_x2 #(.DATA_WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_control   (i_control),
        .i_data      (i_data),
        .o_valid0    (o_valid0),
        .i_ready0    (i_ready0),
        .o_data0     (o_data0),
        .o_valid1    (o_valid1),
        .i_ready1    (i_ready1),
        .o_data1     (o_data1),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard: inputs only change at posedge+1, so at negedge the
    // handshakes about to complete on the next rising edge are known.
    always @(negedge clk) begin
        checks++;
        if (o_valid0 && o_valid1) begin
            failures++;
            $display("FAIL onehot actual=%b%b expected=not both", o_valid0, o_valid1);
        end
        if ((o_valid0 && i_ready0) || (o_valid1 && i_ready1)) begin
            checks++;
            mon_act = o_valid1 ? {1'b1, o_data1} : {1'b0, o_data0};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_order actual=%h expected=%h", mon_act, mon_exp);
                end
            end
        end
        if (i_valid && o_ready) exp_q.push_back({i_control, i_data});
    end

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_control = 1'b0; i_data = '0;
        i_ready0 = 1'b1; i_ready1 = 1'b1;
        #2;
        checks++;
        if ({o_ready, o_valid0, o_valid1} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold actual=%b expected=000", {o_ready, o_valid0, o_valid1});
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_ready, o_valid0, o_valid1} !== 3'b100 || o_dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_release actual=%b st=%0d expected=100 st=0",
                     {o_ready, o_valid0, o_valid1}, o_dbg_state);
        end
        checks++;
        if (o_data0 !== '0 || o_data1 !== '0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h expected=0/0", o_data0, o_data1);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] tab[4];
        logic         prev_sel;
        logic [W-1:0] prev_data;
        tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33; tab[3] = 32'h44;
        i_ready0 = 1'b1; i_ready1 = 1'b1;
        prev_sel = 1'b0; prev_data = '0;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                checks++;
                if ((prev_sel ? o_valid1 : o_valid0) !== 1'b1 ||
                    (prev_sel ? o_valid0 : o_valid1) !== 1'b0 ||
                    (prev_sel ? o_data1 : o_data0) !== prev_data || o_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_%0d actual=v%b%b d0=%h d1=%h rdy=%b expected=port%0d %h",
                             i - 1, o_valid1, o_valid0, o_data0, o_data1, o_ready, prev_sel, prev_data);
                end
            end
            if (i < 4) begin
                i_valid = 1'b1; i_control = i[0]; i_data = tab[i];
                prev_sel = i[0]; prev_data = tab[i];
            end else begin
                i_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle actual=%b%b expected=00", o_valid1, o_valid0);
        end
    endtask

    task automatic test_back_pressure();
        i_ready0 = 1'b1; i_ready1 = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_control = 1'b1; i_data = 32'hA1;
        @(posedge clk); #1;
        checks++;
        if (o_valid1 !== 1'b1 || o_data1 !== 32'hA1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first actual=v1=%b d1=%h rdy=%b expected=1 a1 1", o_valid1, o_data1, o_ready);
        end
        i_control = 1'b0; i_data = 32'hB0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready !== 1'b0 || o_valid1 !== 1'b1 || o_data1 !== 32'hA1 || o_valid0 !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall_%0d actual=rdy=%b v=%b%b d1=%h expected=rdy=0 v=10 d1=a1",
                         k, o_ready, o_valid1, o_valid0, o_data1);
            end
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        i_ready1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_valid0 !== 1'b1 || o_data0 !== 32'hB0 || o_valid1 !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release actual=v=%b%b d0=%h rdy=%b expected=v=01 d0=b0 rdy=1",
                     o_valid1, o_valid0, o_data0, o_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (o_valid0 !== 1'b0 || o_dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL bp_empty actual=v0=%b st=%0d expected=0 st=0", o_valid0, o_dbg_state);
        end
    endtask

    task automatic test_stability();
        i_ready0 = 1'b0; i_ready1 = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b1; i_control = 1'b0; i_data = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b0; i_control = 1'($urandom_range(0, 1)); i_data = $urandom;
            checks++;
            if (o_valid0 !== 1'b1 || o_data0 !== 32'hDEADBEEF || o_valid1 !== 1'b0 || o_dbg_state !== 2'd1) begin
                failures++;
                $display("FAIL stable_%0d actual=v=%b%b d0=%h st=%0d expected=v=01 d0=deadbeef st=1",
                         k, o_valid1, o_valid0, o_data0, o_dbg_state);
            end
        end
        i_ready0 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_valid0 !== 1'b0 || o_valid1 !== 1'b0 || o_dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL stable_drain actual=v=%b%b st=%0d expected=v=00 st=0",
                     o_valid1, o_valid0, o_dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        i_ready0 = 1'b0; i_ready1 = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_control = 1'b0; i_data = 32'h01;
        @(posedge clk); #1;
        i_control = 1'b1; i_data = 32'h02;
        @(posedge clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_dbg_state !== 2'd2 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_fill actual=st=%0d rdy=%b expected=st=2 rdy=0", o_dbg_state, o_ready);
        end
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({o_ready, o_valid0, o_valid1} !== 3'b000 || o_data0 !== '0 || o_data1 !== '0) begin
            failures++;
            $display("FAIL mid_async actual=%b d=%h/%h expected=000 d=0/0",
                     {o_ready, o_valid0, o_valid1}, o_data0, o_data1);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; i_ready0 = 1'b1; i_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_ready, o_valid0, o_valid1} !== 3'b100 || o_dbg_state !== 2'd0) begin
                failures++;
                $display("FAIL mid_after_%0d actual=%b st=%0d expected=100 st=0",
                         k, {o_ready, o_valid0, o_valid1}, o_dbg_state);
            end
        end
    endtask

    task automatic test_zero_idle();
        logic [W-1:0] exp_d0;
        logic [W-1:0] exp_idle;
`ifdef DEMUX_ZERO_IDLE_EN
        exp_d0 = '0; exp_idle = '0;
`else
        exp_d0 = 32'h55; exp_idle = 32'h55;
`endif
        i_ready1 = 1'b0; i_ready0 = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b1; i_control = 1'b1; i_data = 32'h55;
        @(posedge clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_valid1 !== 1'b1 || o_data1 !== 32'h55 || o_data0 !== exp_d0) begin
            failures++;
            $display("FAIL feature_pending actual=v1=%b d1=%h d0=%h expected=v1=1 d1=55 d0=%h",
                     o_valid1, o_data1, o_data0, exp_d0);
        end
        i_ready1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_valid1 !== 1'b0 || o_data1 !== exp_idle) begin
            failures++;
            $display("FAIL feature_idle actual=v1=%b d1=%h expected=v1=0 d1=%h", o_valid1, o_data1, exp_idle);
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!hold) begin
                i_valid   = ($urandom_range(0, 3) != 0);
                i_control = 1'($urandom_range(0, 1));
                i_data    = $urandom;
            end
            i_ready0 = ($urandom_range(0, 3) != 0);
            i_ready1 = ($urandom_range(0, 2) != 0);
            #1;
            hold = i_valid && !o_ready;
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_ready0 = 1'b1; i_ready1 = 1'b1;
        for (int k = 0; k < 20 && (exp_q.size() != 0 || o_valid0 || o_valid1); k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0 || o_valid0 !== 1'b0 || o_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL random_drain actual=left=%0d v=%b%b expected=left=0 v=00",
                     exp_q.size(), o_valid1, o_valid0);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_stability();
        test_reset_mid();
        test_zero_idle();
        test_random();
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
